// File: rtl/game_pkg.sv
// Shared types and default constants for the game flow controller and its bench.
package game_pkg;

    localparam int unsigned DIFF_W  = 2;
    localparam int unsigned SCORE_W = 32;

    localparam int unsigned COUNTDOWN_FRAMES_DEF = 3;
    localparam int unsigned BLOCKS_PER_LEVEL_DEF = 8;
    localparam int unsigned DIFF_INIT_DEF        = 1;
    localparam int unsigned DIFF_MAX_DEF         = 3;
    localparam int unsigned OVER_HOLD_FRAMES_DEF = 60;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RUN       = 2'd2,
        OVER      = 2'd3
    } game_state_t;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game-logic and score-engine signals seen by the flow controller.
interface game_flow_ctrl_if;
    import game_pkg::*;

    logic               frame_tick;
    logic               start_btn;
    logic               block_cleared;
    logic               collision;
    logic [SCORE_W-1:0] score;

    logic               score_start;
    logic               score_in;
    logic [DIFF_W-1:0]  difficulty;
    logic [1:0]         game_state;
    logic [1:0]         countdown;
    logic [SCORE_W-1:0] high_score;
    logic               new_high;

    // Controller side.
    modport master (
        input  frame_tick, start_btn, block_cleared, collision, score,
        output score_start, score_in, difficulty, game_state, countdown, high_score, new_high
    );

    // Game logic / score engine side.
    modport slave (
        output frame_tick, start_btn, block_cleared, collision, score,
        input  score_start, score_in, difficulty, game_state, countdown, high_score, new_high
    );

endinterface

// File: rtl/rise_edge_det.sv
// Single-cycle pulse on the rising edge of an already-synchronised level.
module rise_edge_det (
    input  logic clock_div,
    input  logic reset_n,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clock_div or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer: drives the score engine, ramps difficulty, tracks high score.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned COUNTDOWN_FRAMES = COUNTDOWN_FRAMES_DEF,
    parameter int unsigned BLOCKS_PER_LEVEL = BLOCKS_PER_LEVEL_DEF,
    parameter int unsigned DIFF_INIT        = DIFF_INIT_DEF,
    parameter int unsigned DIFF_MAX         = DIFF_MAX_DEF,
    parameter int unsigned OVER_HOLD_FRAMES = OVER_HOLD_FRAMES_DEF
) (
    input  logic             clock_div,
    input  logic             reset_n,
    game_flow_ctrl_if.master bus
);

    localparam int unsigned LVL_W  = $clog2(BLOCKS_PER_LEVEL) + 1;
    localparam int unsigned HOLD_W = $clog2(OVER_HOLD_FRAMES) + 1;

    game_state_t        state_q, state_d;
    logic [1:0]         countdown_q, countdown_d;
    logic [DIFF_W-1:0]  diff_q, diff_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               score_start_q, score_start_d;
    logic               score_in_q, score_in_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               new_high_q, new_high_d;
    logic               start_edge;

    rise_edge_det u_start_edge (
        .clock_div (clock_div),
        .reset_n   (reset_n),
        .in        (bus.start_btn),
        .pulse     (start_edge)
    );

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        diff_d      = diff_q;
        level_d     = level_q;
        hold_d      = hold_q;
        high_d      = high_q;
        new_high_d  = new_high_q;
        score_in_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = COUNTDOWN;
                    countdown_d = 2'(COUNTDOWN_FRAMES);
                    diff_d      = DIFF_W'(DIFF_INIT);
                    level_d     = '0;
                    new_high_d  = 1'b0;
                end
            end
            COUNTDOWN: begin
                if (bus.frame_tick) begin
                    if (countdown_q == 2'd1) begin
                        countdown_d = 2'd0;
                        state_d     = RUN;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end
            end
            RUN: begin
                // A collision in the same cycle as a clear forfeits that block.
                if (bus.collision) begin
                    state_d = OVER;
                    hold_d  = '0;
                end else if (bus.block_cleared) begin
                    score_in_d = 1'b1;
                    if (level_q == LVL_W'(BLOCKS_PER_LEVEL - 1)) begin
                        level_d = '0;
                        if (diff_q < DIFF_W'(DIFF_MAX)) begin
                            diff_d = diff_q + DIFF_W'(1);
                        end
                    end else begin
                        level_d = level_q + LVL_W'(1);
                    end
                end
            end
            OVER: begin
                // Compared every cycle so a late final score update is still caught.
                if (bus.score > high_q) begin
                    high_d     = bus.score;
                    new_high_d = 1'b1;
                end
                if (bus.frame_tick) begin
                    if (hold_q == HOLD_W'(OVER_HOLD_FRAMES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        score_start_d = (state_d == RUN) || (state_d == OVER);
    end

    always_ff @(posedge clock_div or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            countdown_q   <= 2'd0;
            diff_q        <= DIFF_W'(DIFF_INIT);
            level_q       <= '0;
            hold_q        <= '0;
            score_start_q <= 1'b0;
            score_in_q    <= 1'b0;
            high_q        <= '0;
            new_high_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            diff_q        <= diff_d;
            level_q       <= level_d;
            hold_q        <= hold_d;
            score_start_q <= score_start_d;
            score_in_q    <= score_in_d;
            high_q        <= high_d;
            new_high_q    <= new_high_d;
        end
    end

    assign bus.score_start = score_start_q;
    assign bus.score_in    = score_in_q;
    assign bus.difficulty  = diff_q;
    assign bus.game_state  = state_q;
    assign bus.countdown   = countdown_q;
    assign bus.high_score  = high_q;
    assign bus.new_high    = new_high_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table for start/countdown plus hand sequences.
module tb_game_flow_ctrl;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    game_flow_ctrl_if bus ();

    game_flow_ctrl dut (
        .clock_div (clk),
        .reset_n   (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic       ft;
        logic       sb;
        logic       bc;
        logic       col;
        logic [1:0] st;
        logic [1:0] cd;
        logic       ss;
        logic       si;
        logic [1:0] df;
    } vec_t;

    vec_t vecs [9];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ft, input logic sb, input logic bc, input logic col);
        bus.frame_tick    = ft;
        bus.start_btn     = sb;
        bus.block_cleared = bc;
        bus.collision     = col;
    endtask

    int blocks;
    int exp_diff;

    initial begin
        // inputs -> expected state, countdown, score_start, score_in, difficulty
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 2'd1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 2'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 2'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 2'd1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 2'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 2'd1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b1, 2'd1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 2'd1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 2'd1};

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        bus.score = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_state", 32'(bus.game_state), 32'd0);
        chk("rst_score_start", 32'(bus.score_start), 32'd0);
        chk("rst_score_in", 32'(bus.score_in), 32'd0);
        chk("rst_difficulty", 32'(bus.difficulty), 32'd1);
        chk("rst_countdown", 32'(bus.countdown), 32'd0);
        chk("rst_high_score", bus.high_score, 32'd0);
        chk("rst_new_high", 32'(bus.new_high), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_after_rst", 32'(bus.game_state), 32'd0);

        // Start, countdown (with ignored edge/events), first RUN cycles
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].ft, vecs[i].sb, vecs[i].bc, vecs[i].col);
            step();
            chk($sformatf("vec%0d_state", i), 32'(bus.game_state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_countdown", i), 32'(bus.countdown), 32'(vecs[i].cd));
            chk($sformatf("vec%0d_score_start", i), 32'(bus.score_start), 32'(vecs[i].ss));
            chk($sformatf("vec%0d_score_in", i), 32'(bus.score_in), 32'(vecs[i].si));
            chk($sformatf("vec%0d_difficulty", i), 32'(bus.difficulty), 32'(vecs[i].df));
        end

        // Remaining 31 blocks: ramp at 8 and 16, saturate at 3 afterwards
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        blocks = 1;
        for (int k = 2; k <= 32; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            step();
            blocks   = k;
            exp_diff = 1 + blocks / 8;
            if (exp_diff > 3) exp_diff = 3;
            chk($sformatf("blk%0d_score_in", k), 32'(bus.score_in), 32'd1);
            chk($sformatf("blk%0d_difficulty", k), 32'(bus.difficulty), 32'(exp_diff));
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            step();
            chk($sformatf("blk%0d_score_in_low", k), 32'(bus.score_in), 32'd0);
        end

        // Collision beats a simultaneous clear
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        bus.score = 32'd5;
        step();
        chk("col_score_in", 32'(bus.score_in), 32'd0);
        chk("col_state", 32'(bus.game_state), 32'd3);
        chk("col_score_start", 32'(bus.score_start), 32'd1);
        chk("col_difficulty", 32'(bus.difficulty), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("g1_high_score", bus.high_score, 32'd5);
        chk("g1_new_high", 32'(bus.new_high), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("over_start_ignored", 32'(bus.game_state), 32'd3);

        // OVER hold: 60 frame ticks back to IDLE
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 30) chk("over_diff_frozen", 32'(bus.difficulty), 32'd3);
            if (i == 59) chk("over_hold59_state", 32'(bus.game_state), 32'd3);
            if (i == 60) begin
                chk("over_exit_state", 32'(bus.game_state), 32'd0);
                chk("over_exit_score_start", 32'(bus.score_start), 32'd0);
            end
        end

        // Game 2 ends at a lower score
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        bus.score = '0;
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("g2_start_state", 32'(bus.game_state), 32'd1);
        chk("g2_new_high_cleared", 32'(bus.new_high), 32'd0);
        chk("g2_diff_reinit", 32'(bus.difficulty), 32'd1);
        chk("g2_high_kept", bus.high_score, 32'd5);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("g2_run_state", 32'(bus.game_state), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        bus.score = 32'd3;
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("g2_over_state", 32'(bus.game_state), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("g2_high_kept_over", bus.high_score, 32'd5);
        chk("g2_new_high_low", 32'(bus.new_high), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step();
        chk("g2_back_idle", 32'(bus.game_state), 32'd0);

        // Game 3: asynchronous reset in RUN
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        bus.score = '0;
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("g3_run_state", 32'(bus.game_state), 32'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("g3_score_in", 32'(bus.score_in), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(bus.game_state), 32'd0);
        chk("arst_score_start", 32'(bus.score_start), 32'd0);
        chk("arst_score_in", 32'(bus.score_in), 32'd0);
        chk("arst_difficulty", 32'(bus.difficulty), 32'd1);
        chk("arst_high_score", bus.high_score, 32'd0);
        chk("arst_new_high", 32'(bus.new_high), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_arst_state", 32'(bus.game_state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level sequencer for the score engine.
- Runs the game through idle, countdown, run and game-over phases, and drives the score engine's start, score pulse and difficulty inputs.
- Ramps difficulty as blocks are cleared and keeps a persistent high score.
- Sits between the game logic (frame tick, block/collision events, start button) and the score engine.

Parameters:
- COUNTDOWN_FRAMES, 3, frames spent in COUNTDOWN before RUN; legal range 1..3.
- BLOCKS_PER_LEVEL, 8, cleared blocks per difficulty step; must be at least 1.
- DIFF_INIT, 1, difficulty loaded at each game start.
- DIFF_MAX, 3, saturation value for difficulty.
- OVER_HOLD_FRAMES, 60, frames held in OVER before returning to IDLE; must be at least 1.

Ports:
- clock_div  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start_btn  in  1  start button level, already synchronised; its rising edge is detected internally.
- block_cleared  in  1  one-cycle pulse per block jumped.
- collision  in  1  collision indicator; any high cycle counts.
- score  in  32  current score from the score engine.
- score_start  out  1  drives the score engine start input; low clears the score.
- score_in  out  1  one-cycle pulse per scored block.
- difficulty  out  2  current difficulty, 0..3.
- game_state  out  2  IDLE=0, COUNTDOWN=1, RUN=2, OVER=3.
- countdown  out  2  remaining countdown frames; 0 outside COUNTDOWN.
- high_score  out  32  best score since reset.
- new_high  out  1  high when the last game set a new high score.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, score_start=0, score_in=0, difficulty=DIFF_INIT, countdown=0.
  - high_score=0, new_high=0, level count=0, hold count=0.
  - start_btn edge register cleared.
- Start edge: start_edge = start_btn & ~start_q, with start_q registered every cycle. The edge is acted on only in IDLE; edges in any other state are ignored.
- IDLE:
  - score_start=0.
  - On start_edge: go to COUNTDOWN, countdown<=COUNTDOWN_FRAMES, difficulty<=DIFF_INIT, level count<=0, new_high<=0.
- COUNTDOWN:
  - score_start=0.
  - Each frame_tick decrements countdown.
  - frame_tick while countdown==1: countdown<=0, go to RUN.
  - block_cleared and collision are ignored.
- RUN:
  - score_start=1, asserted from the first RUN cycle.
  - block_cleared with collision low: score_in is high exactly the next cycle (latency 1), and level count increments.
  - When level count is BLOCKS_PER_LEVEL-1 and a block is cleared: level count wraps to 0 and difficulty<=min(difficulty+1, DIFF_MAX).
  - collision: go to OVER next cycle, hold count<=0.
  - collision and block_cleared in the same cycle: collision wins; no score_in pulse and no level or difficulty change.
- OVER:
  - score_start stays 1 so the final score is preserved.
  - difficulty is frozen.
  - Every cycle in OVER: if score > high_score (unsigned), then high_score<=score and new_high<=1. This absorbs score engine latency.
  - Each frame_tick increments hold count.
  - frame_tick while hold count==OVER_HOLD_FRAMES-1: go to IDLE. score_start drops in IDLE, which clears the score engine.
- Timing and widths:
  - score_in is never high for two consecutive cycles unless block_cleared was.
  - All outputs are registered.
  - Level count width is $clog2(BLOCKS_PER_LEVEL)+1.
  - Hold count width is $clog2(OVER_HOLD_FRAMES)+1.
  - high_score holds across games and clears only on reset.
- Reset mid-game: state returns to IDLE immediately and high_score clears to 0.

Decomposition:
- Package game_pkg:
  - game_state_t enum (IDLE, COUNTDOWN, RUN, OVER).
  - DIFF_W=2 and SCORE_W=32.
  - Default parameter constants.
- One sub-module, rise_edge_det (clock_div, reset_n, in, pulse), used for start_btn.
- The FSM, counters and high-score register stay in game_flow_ctrl.

Test Plan:
- Reset then start_btn rising edge in IDLE:
  - Next cycle: game_state=1, countdown=3.
  - After 3 frame_ticks: game_state=2, score_start=1, difficulty=1.
- In RUN, 8 block_cleared pulses (BLOCKS_PER_LEVEL=8): 8 score_in pulses, each 1 cycle after its input; difficulty goes 1->2 after the 8th.
- 24 more blocks: difficulty saturates at 3 and does not wrap.
- block_cleared and collision in the same cycle: no score_in pulse; game_state=3 next cycle; score_start stays 1.
- Game 1 ends with score=5, game 2 with score=3:
  - After game 1: high_score=5, new_high=1.
  - During game 2: new_high=0 after its start; high_score stays 5.
- Timing edges:
  - start_btn edges during COUNTDOWN, RUN and OVER are ignored.
  - After 60 frame_ticks in OVER: game_state=0, score_start=0.
  - reset_n pulsed low in RUN: all outputs return to reset values asynchronously.
